fifo_wr_arbiter: RTL

- Round-robin write arbiter that shares one synchronous FIFO write port among NUM_REQ producers.
- Each producer offers packets over a valid/ready/last stream.
- The arbiter locks the FIFO write port to one producer for a burst, drives fifo_wr_en/fifo_wr_data and honours fifo_full.
- It sits between producer blocks and the shared FIFO instance.

---
 rtl/fifo_pkg.sv | 19 +
 rtl/rr_pick.sv | 27 ++
 rtl/fifo_wr_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-side arbitration blocks.
package fifo_pkg;

    // Default word width. Keep this equal to the width of the shared FIFO instance.
    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_NUM_REQ    = 4;
    localparam int DEFAULT_MAX_BURST  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Index width for an n-entry selector. It never returns zero, so a port width stays legal.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set request after rr_ptr.
// The entry at rr_ptr is checked last, so it has the lowest priority.
module rr_pick
    import fifo_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int IDW     = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     rr_ptr,
    output logic [IDW-1:0]     winner,
    output logic               any
);

    // Scan from the farthest offset down to the nearest one. The last hit overwrites
    // the earlier ones, so the nearest request after rr_ptr wins.
    always_comb begin
        winner = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[(int'(rr_ptr) + k) % NUM_REQ]) begin
                winner = IDW'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
        any = |req;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ packet producers.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no owner; choose the next requester, accept no data
//   BURST | port locked to grant_id; beats pass straight through to the FIFO
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_REQ    = DEFAULT_NUM_REQ,
    parameter int MAX_BURST  = DEFAULT_MAX_BURST
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    input  logic                          fifo_full,
    output logic                          grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          burst_trunc
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(MAX_BURST + 1);

    arb_state_t     state, state_nx;
    logic [IDW-1:0] gid_nx;
    logic [CW-1:0]  beat_cnt, cnt_nx;
    logic [IDW-1:0] rr_ptr, ptr_nx;
    logic           trunc_nx;
    logic [IDW-1:0] pick_id;
    logic           pick_any;
    logic           accept;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .winner (pick_id),
        .any    (pick_any)
    );

    // State and bookkeeping registers. The reset value of rr_ptr gives requester 0 first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant_id    <= '0;
            beat_cnt    <= '0;
            rr_ptr      <= IDW'(NUM_REQ - 1);
            burst_trunc <= 1'b0;
        end else begin
            state       <= state_nx;
            grant_id    <= gid_nx;
            beat_cnt    <= cnt_nx;
            rr_ptr      <= ptr_nx;
            burst_trunc <= trunc_nx;
        end
    end

    // Next-state logic plus the pass-through write path from the current owner.
    always_comb begin
        state_nx     = state;
        gid_nx       = grant_id;
        cnt_nx       = beat_cnt;
        ptr_nx       = rr_ptr;
        trunc_nx     = 1'b0;
        req_ready    = '0;
        accept       = 1'b0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];

        case (state)
            IDLE: begin
                if (pick_any) begin
                    gid_nx   = pick_id;
                    cnt_nx   = '0;
                    state_nx = BURST;
                end
            end
            BURST: begin
                req_ready[grant_id] = !fifo_full;
                accept              = req_valid[grant_id] && !fifo_full;
                fifo_wr_en          = accept;
                if (accept) begin
                    cnt_nx = beat_cnt + 1'b1;
                    if (req_last[grant_id]) begin
                        state_nx = IDLE;
                        ptr_nx   = grant_id;
                    end else if (beat_cnt == CW'(MAX_BURST - 1)) begin
                        // This beat was the last one the burst allows. Release the port and
                        // flag the truncation; the packet continues on a later grant.
                        state_nx = IDLE;
                        ptr_nx   = grant_id;
                        trunc_nx = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign grant_valid = (state == BURST);

endmodule
